// File: rtl/gb80_pkg.sv
// gb80_pkg: shared decode types and LR35902 opcode classification helpers.
package gb80_pkg;

    typedef enum logic [1:0] {S_OPC, S_CB, S_IMM_LO, S_IMM_HI} state_t;

    localparam int PC_W = 16;
    localparam logic [7:0] CB_PREFIX = 8'hCB;

    typedef struct packed {
        logic [7:0]      opcode;
        logic            cb;
        logic [15:0]     imm;
        logic [1:0]      len;
        logic [PC_W-1:0] pc;
        logic            illegal;
    } op_rec_t;

    function automatic logic [1:0] imm_len(input logic [7:0] op);
        return op inside {8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
                          8'h10, 8'h18, 8'h20, 8'h28, 8'h30, 8'h38,
                          8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE,
                          8'hE0, 8'hF0, 8'hE8, 8'hF8} ? 2'd1 :
               op inside {8'h01, 8'h11, 8'h21, 8'h31, 8'h08,
                          8'hC2, 8'hC3, 8'hCA, 8'hD2, 8'hDA,
                          8'hC4, 8'hCC, 8'hCD, 8'hD4, 8'hDC,
                          8'hEA, 8'hFA} ? 2'd2 : 2'd0;
    endfunction

    function automatic logic is_illegal(input logic [7:0] op);
        return op inside {8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB,
                          8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD};
    endfunction

endpackage

// File: rtl/gb80_opq.sv
// gb80_opq: show-ahead FIFO of decoded-op records with occupancy count and sync clear.
module gb80_opq import gb80_pkg::*; #(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   push,
    input  logic                   pop,
    input  op_rec_t                din,
    output op_rec_t                dout,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    op_rec_t        mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_pop;

    assign do_pop = pop & (count != '0);
    // Zero the head when empty so the record outputs read as 0 after reset and flush.
    assign dout   = (count != '0) ? mem[rd_ptr] : '0;

    always_ff @(posedge clk)
        if (push && !clr) mem[wr_ptr] <= din;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, do_pop};
        end

endmodule

// File: rtl/gb80_decode_seq.sv
// gb80_decode_seq: assembles 1-3 byte LR35902 instructions from the fetch byte stream
// into PC-tagged records and queues them for the execute control unit.
module gb80_decode_seq import gb80_pkg::*; #(
    parameter int ADDR_W    = 16,
    parameter int OPQ_DEPTH = 2,
    parameter bit ENABLE_CB = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [7:0]        op_opcode,
    output logic              op_cb,
    output logic [15:0]       op_imm,
    output logic [1:0]        op_len,
    output logic [ADDR_W-1:0] op_pc,
    output logic              op_illegal,
    output logic              busy
);

    localparam int CW = $clog2(OPQ_DEPTH) + 1;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] start_pc;
    logic [7:0]        opc;
    logic [7:0]        imm_lo;
    logic [CW-1:0]     count;
    logic [CW-1:0]     next_count;
    logic              accept;
    logic              is_pfx;
    logic [1:0]        imm_n;
    logic [1:0]        opc_n;
    logic              push;
    logic              pop;
    op_rec_t           rec;
    op_rec_t           head;

    assign accept = byte_valid & byte_ready & ~flush;
    assign is_pfx = ENABLE_CB && byte_data == CB_PREFIX;
    assign imm_n  = imm_len(byte_data);
    assign opc_n  = imm_len(opc);
    assign pop    = op_ready & op_valid;

    // A record is pushed on the byte that completes an instruction.
    assign push = accept & (state == S_OPC    ? (!is_pfx && imm_n == 2'd0) :
                            state == S_IMM_LO ? (opc_n == 2'd1) : 1'b1);

    assign rec = '{
        opcode:  (state == S_OPC || state == S_CB) ? byte_data : opc,
        cb:      state == S_CB,
        imm:     state == S_IMM_LO ? {8'h00, byte_data} :
                 state == S_IMM_HI ? {byte_data, imm_lo} : 16'h0000,
        len:     state == S_OPC ? 2'd1 : state == S_IMM_HI ? 2'd3 : 2'd2,
        pc:      PC_W'(state == S_OPC ? pc : start_pc),
        illegal: state == S_OPC && (is_illegal(byte_data) || (!ENABLE_CB && byte_data == CB_PREFIX))
    };

    assign next_count = count + CW'(push) - CW'(pop);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state      <= S_OPC;
            pc         <= '0;
            start_pc   <= '0;
            opc        <= '0;
            imm_lo     <= '0;
            byte_ready <= 1'b0;
        end else begin
            byte_ready <= !flush && next_count < CW'(OPQ_DEPTH);
            if (flush) begin
                state <= S_OPC;
                pc    <= flush_pc;
            end else if (accept) begin
                pc <= pc + 1'b1;
                case (state)
                    S_OPC: begin
                        opc      <= byte_data;
                        start_pc <= pc;
                        state    <= is_pfx ? S_CB : (imm_n != 2'd0 ? S_IMM_LO : S_OPC);
                    end
                    S_IMM_LO: begin
                        imm_lo <= byte_data;
                        state  <= opc_n == 2'd1 ? S_OPC : S_IMM_HI;
                    end
                    default: state <= S_OPC;
                endcase
            end
        end

    gb80_opq #(.DEPTH(OPQ_DEPTH)) u_opq (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .push  (push),
        .pop   (pop),
        .din   (rec),
        .dout  (head),
        .count (count)
    );

    assign op_valid   = count != '0;
    assign op_opcode  = head.opcode;
    assign op_cb      = head.cb;
    assign op_imm     = head.imm;
    assign op_len     = head.len;
    assign op_pc      = head.pc[ADDR_W-1:0];
    assign op_illegal = head.illegal;
    assign busy       = state != S_OPC || op_valid;

endmodule

// File: tb/tb_gb80_decode_seq.sv
// tb_gb80_decode_seq: randomized and directed checks of the decode sequencer against
// a stream-level reference decoder; a second instance covers ENABLE_CB = 0.
module tb_gb80_decode_seq;

    logic        clk = 0, rst_n = 0, flush = 0, byte_valid = 0, byte_valid_1 = 0, op_ready = 0;
    logic [15:0] flush_pc = '0;
    logic [7:0]  byte_data = '0;

    logic        byte_ready, op_valid, op_cb, op_illegal, busy;
    logic [7:0]  op_opcode;
    logic [15:0] op_imm, op_pc;
    logic [1:0]  op_len;
    logic        byte_ready_1, op_valid_1, op_cb_1, op_illegal_1, busy_1;
    logic [7:0]  op_opcode_1;
    logic [15:0] op_imm_1, op_pc_1;
    logic [1:0]  op_len_1;

    int tests = 0, fails = 0;
    bit feed1 = 0;

    typedef struct packed {
        logic [7:0]  opc;
        logic        cb;
        logic [15:0] imm;
        logic [1:0]  len;
        logic [15:0] pc;
        logic        ill;
    } rec_t;

    rec_t got[$], got1[$], exp[$];

    gb80_decode_seq dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .flush_pc(flush_pc),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .op_valid(op_valid), .op_ready(op_ready), .op_opcode(op_opcode), .op_cb(op_cb),
        .op_imm(op_imm), .op_len(op_len), .op_pc(op_pc), .op_illegal(op_illegal), .busy(busy)
    );

    gb80_decode_seq #(.ENABLE_CB(1'b0)) dut_nocb (
        .clk(clk), .rst_n(rst_n), .flush(flush), .flush_pc(flush_pc),
        .byte_valid(byte_valid_1), .byte_data(byte_data), .byte_ready(byte_ready_1),
        .op_valid(op_valid_1), .op_ready(op_ready), .op_opcode(op_opcode_1), .op_cb(op_cb_1),
        .op_imm(op_imm_1), .op_len(op_len_1), .op_pc(op_pc_1), .op_illegal(op_illegal_1), .busy(busy_1)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (rst_n && !flush && op_ready) begin
            if (op_valid) got.push_back('{op_opcode, op_cb, op_imm, op_len, op_pc, op_illegal});
            if (op_valid_1) got1.push_back('{op_opcode_1, op_cb_1, op_imm_1, op_len_1, op_pc_1, op_illegal_1});
        end

    // Reference: decode a whole byte stream into the records it must produce.
    function automatic void build_exp(input logic [7:0] b[$], input logic [15:0] pc0, input bit en);
        int i = 0;
        int n;
        logic [15:0] p = pc0;
        logic [15:0] imm;
        logic [7:0] op;
        exp.delete();
        while (i < b.size()) begin
            op = b[i];
            n = op inside {8'h01, 8'h11, 8'h21, 8'h31, 8'h08, 8'hC2, 8'hC3, 8'hCA, 8'hD2, 8'hDA,
                           8'hC4, 8'hCC, 8'hCD, 8'hD4, 8'hDC, 8'hEA, 8'hFA} ? 2 :
                op inside {8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E, 8'h10,
                           8'h18, 8'h20, 8'h28, 8'h30, 8'h38, 8'hC6, 8'hCE, 8'hD6, 8'hDE,
                           8'hE6, 8'hEE, 8'hF6, 8'hFE, 8'hE0, 8'hF0, 8'hE8, 8'hF8} ? 1 : 0;
            if (en && op == 8'hCB) begin
                if (i + 1 >= b.size()) break;
                exp.push_back('{b[i+1], 1'b1, 16'h0000, 2'd2, p, 1'b0});
                i += 2;
                p = p + 16'd2;
            end else begin
                if (i + n >= b.size()) break;
                imm = 16'h0000;
                if (n >= 1) imm[7:0] = b[i+1];
                if (n == 2) imm[15:8] = b[i+2];
                exp.push_back('{op, 1'b0, imm, 2'(n + 1), p,
                    op inside {8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB, 8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD, 8'hCB}});
                i += n + 1;
                p = p + 16'(n + 1);
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush(input logic [15:0] p);
        flush = 1;
        flush_pc = p;
        byte_valid = 0;
        byte_valid_1 = 0;
        tick();
        flush = 0;
        got.delete();
        got1.delete();
    endtask

    task automatic send(input logic [7:0] b[$], input bit rnd);
        int i = 0;
        int t = 0;
        bit acc;
        while (i < b.size() && t < 2000) begin
            if (rnd) op_ready = 1'($urandom_range(0, 1));
            byte_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            byte_valid_1 = feed1 ? byte_valid : 1'b0;
            byte_data = b[i];
            acc = byte_valid && byte_ready && (!feed1 || byte_ready_1);
            tick();
            if (acc) i++;
            t++;
        end
        byte_valid = 0;
        byte_valid_1 = 0;
        tests++;
        if (i != b.size()) begin
            fails++;
            $display("FAIL send_timeout: accepted %0d bytes, required %0d", i, b.size());
        end
    endtask

    task automatic drain();
        int t = 0;
        op_ready = 1;
        while ((op_valid || op_valid_1) && t < 50) begin
            tick();
            t++;
        end
        tests++;
        if (op_valid || op_valid_1) begin
            fails++;
            $display("FAIL drain_timeout: op_valid %0b/%0b still set, required 0", op_valid, op_valid_1);
        end
    endtask

    task automatic test_reset();
        #2;
        tests++;
        if ({byte_ready, op_valid, busy} !== 3'b000) begin
            fails++;
            $display("FAIL reset_ctrl: ready/valid/busy=%b, required 000", {byte_ready, op_valid, busy});
        end
        tests++;
        if ({op_opcode, op_cb, op_imm, op_len, op_pc, op_illegal} !== '0) begin
            fails++;
            $display("FAIL reset_fields: %h, required 0", {op_opcode, op_cb, op_imm, op_len, op_pc, op_illegal});
        end
        tick();
        tick();
        rst_n = 1;
        tests++;
        if (byte_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_release_ready: %b, required 0", byte_ready);
        end
        tick();
        tests++;
        if (byte_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready_rise: %b, required 1", byte_ready);
        end
    endtask

    task automatic test_basic();
        logic [7:0] b[$];
        rec_t e[3];
        rec_t cur;
        int j = 0;
        b = '{8'h00, 8'h3E, 8'h42, 8'hC3, 8'h34, 8'h12};
        e = '{'{8'h00, 1'b0, 16'h0000, 2'd1, 16'h0100, 1'b0},
              '{8'h3E, 1'b0, 16'h0042, 2'd2, 16'h0101, 1'b0},
              '{8'hC3, 1'b0, 16'h1234, 2'd3, 16'h0103, 1'b0}};
        op_ready = 1;
        do_flush(16'h0100);
        tick();
        for (int k = 0; k < 6; k++) begin
            byte_valid = 1;
            byte_data = b[k];
            tick();
            cur = '{op_opcode, op_cb, op_imm, op_len, op_pc, op_illegal};
            tests++;
            if (k == 0 || k == 2 || k == 5) begin
                if (!op_valid || cur !== e[j]) begin
                    fails++;
                    $display("FAIL basic_rec%0d: valid %b rec %h, required valid 1 rec %h", j, op_valid, cur, e[j]);
                end
                j++;
            end else if (op_valid !== 1'b0) begin
                fails++;
                $display("FAIL basic_idle%0d: op_valid %b, required 0", k, op_valid);
            end
        end
        byte_valid = 0;
        drain();
        tests++;
        if (got.size() != 3) begin
            fails++;
            $display("FAIL basic_count: %0d records, required 3", got.size());
        end
    endtask

    task automatic test_cb();
        logic [7:0] b[$];
        b = '{8'hCB, 8'h7C};
        op_ready = 1;
        do_flush(16'h0500);
        tick();
        feed1 = 1;
        send(b, 0);
        feed1 = 0;
        drain();
        build_exp(b, 16'h0500, 1);
        tests++;
        if (got.size() != 1 || got[0] !== exp[0] || exp[0] !== rec_t'({8'h7C, 1'b1, 16'h0, 2'd2, 16'h0500, 1'b0})) begin
            fails++;
            $display("FAIL cb_prefix: %0d recs first %h, required 1 rec %h", got.size(), got.size() ? got[0] : rec_t'(0), exp[0]);
        end
        build_exp(b, 16'h0500, 0);
        tests++;
        if (got1.size() != exp.size()) begin
            fails++;
            $display("FAIL nocb_count: %0d records, required %0d", got1.size(), exp.size());
        end else
            for (int i = 0; i < exp.size(); i++) begin
                tests++;
                if (got1[i] !== exp[i]) begin
                    fails++;
                    $display("FAIL nocb_rec%0d: %h, required %h", i, got1[i], exp[i]);
                end
            end
    endtask

    task automatic test_backpressure();
        logic [7:0] b[$];
        int acc = 0;
        bit full_seen = 0;
        for (int i = 0; i < 10; i++) b.push_back(8'h00);
        op_ready = 0;
        do_flush(16'h0300);
        tick();
        for (int c = 0; c < 10; c++) begin
            byte_valid = 1;
            byte_data = 8'h00;
            if (byte_ready) acc++;
            tick();
            if (acc == 2 && !full_seen) begin
                full_seen = 1;
                tests++;
                if (byte_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL bp_ready_drop: byte_ready %b after fill, required 0", byte_ready);
                end
            end
        end
        byte_valid = 0;
        tests++;
        if (acc != 2) begin
            fails++;
            $display("FAIL bp_accept: accepted %0d, required 2", acc);
        end
        op_ready = 1;
        for (int i = 0; i < acc; i++) void'(b.pop_front());
        send(b, 0);
        drain();
        b.delete();
        for (int i = 0; i < 10; i++) b.push_back(8'h00);
        build_exp(b, 16'h0300, 1);
        tests++;
        if (got.size() != 10) begin
            fails++;
            $display("FAIL bp_count: %0d records, required 10", got.size());
        end else
            for (int i = 0; i < 10; i++) begin
                tests++;
                if (got[i] !== exp[i]) begin
                    fails++;
                    $display("FAIL bp_rec%0d: %h, required %h", i, got[i], exp[i]);
                end
            end
    endtask

    task automatic test_flush();
        logic [7:0] b[$];
        rec_t want;
        want = '{8'h01, 1'b0, 16'hBBAA, 2'd3, 16'h2000, 1'b0};
        op_ready = 0;
        do_flush(16'h1000);
        tick();
        b = '{8'h00, 8'hCD, 8'h00};
        send(b, 0);
        tests++;
        if (!(busy && op_valid)) begin
            fails++;
            $display("FAIL flush_pre: busy %b valid %b, required 1 1", busy, op_valid);
        end
        do_flush(16'h2000);
        tests++;
        if ({op_valid, byte_ready, busy} !== 3'b000) begin
            fails++;
            $display("FAIL flush_state: valid/ready/busy=%b, required 000", {op_valid, byte_ready, busy});
        end
        op_ready = 1;
        b = '{8'h01, 8'hAA, 8'hBB};
        send(b, 0);
        drain();
        tests++;
        if (got.size() != 1 || got[0] !== want) begin
            fails++;
            $display("FAIL flush_next: %0d recs first %h, required 1 rec %h", got.size(), got.size() ? got[0] : rec_t'(0), want);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] b[$];
        b = '{8'hEA, 8'h11, 8'h22, 8'h00};
        op_ready = 1;
        do_flush(16'hFFFF);
        send(b, 0);
        drain();
        tests++;
        if (got.size() != 2 || got[0].pc !== 16'hFFFF || got[0].imm !== 16'h2211 || got[1].pc !== 16'h0002) begin
            fails++;
            $display("FAIL wrap: %0d recs pc0 %h imm0 %h pc1 %h, required 2 recs FFFF 2211 0002", got.size(),
                     got.size() > 0 ? got[0].pc : 16'h0, got.size() > 0 ? got[0].imm : 16'h0, got.size() > 1 ? got[1].pc : 16'h0);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b[$];
        rec_t want;
        want = '{8'h3E, 1'b0, 16'h0055, 2'd2, 16'h0000, 1'b0};
        op_ready = 1;
        do_flush(16'h4000);
        b = '{8'hFA, 8'h11};
        send(b, 0);
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_busy: %b, required 1", busy);
        end
        #3;
        rst_n = 0;
        #1;
        tests++;
        if ({byte_ready, op_valid, busy, op_pc, op_opcode} !== '0) begin
            fails++;
            $display("FAIL rstmid_async: ready %b valid %b busy %b pc %h, required all 0", byte_ready, op_valid, busy, op_pc);
        end
        tick();
        rst_n = 1;
        got.delete();
        tick();
        tests++;
        if (byte_ready !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_ready: %b, required 1", byte_ready);
        end
        b = '{8'h3E, 8'h55};
        send(b, 0);
        drain();
        tests++;
        if (got.size() != 1 || got[0] !== want) begin
            fails++;
            $display("FAIL rstmid_fresh: %0d recs first %h, required 1 rec %h", got.size(), got.size() ? got[0] : rec_t'(0), want);
        end
    endtask

    task automatic test_random();
        logic [7:0] b[$];
        logic [15:0] p;
        for (int r = 0; r < 4; r++) begin
            b.delete();
            for (int i = 0; i < 60; i++) b.push_back(8'($urandom_range(0, 255)));
            p = 16'($urandom_range(0, 65535));
            do_flush(p);
            send(b, 1);
            drain();
            build_exp(b, p, 1);
            tests++;
            if (got.size() != exp.size()) begin
                fails++;
                $display("FAIL rand%0d_count: %0d records, required %0d", r, got.size(), exp.size());
            end else
                for (int i = 0; i < exp.size(); i++) begin
                    tests++;
                    if (got[i] !== exp[i]) begin
                        fails++;
                        $display("FAIL rand%0d_rec%0d: %h, required %h", r, i, got[i], exp[i]);
                    end
                end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_cb();
        test_backpressure();
        test_flush();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
